// File: rtl/add_num_pkg.sv
// Shared types and defaults for the add-two-numbers AFU datapath.
// Used by the operand-fetch stage and the downstream adder/write-back stage.
package add_num_pkg;

    localparam int DEFAULT_OP_W = 8;
    localparam logic [11:0] DEFAULT_MDATA_TAG = 12'hADD;

    localparam int CL_ADDR_W = 42;
    localparam int CL_DATA_W = 512;
    localparam int MDATA_W   = 16;
    localparam int SEQ_W     = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_RSP = 2'd2,
        OUT      = 2'd3
    } t_fetch_state;

    typedef struct packed {
        logic [DEFAULT_OP_W-1:0] op_a;
        logic [DEFAULT_OP_W-1:0] op_b;
    } t_add_operands;

    // The sequence number in the low bits lets stale responses be told apart.
    function automatic logic [MDATA_W-1:0] make_mdata(
        input logic [MDATA_W-SEQ_W-1:0] tag,
        input logic [SEQ_W-1:0]         seq
    );
        return {tag, seq};
    endfunction

endpackage

// File: rtl/add_num_operand_fetch_if.sv
// Command, CCI-P c0 read and operand hand-off signals of the operand-fetch stage.
// master = the fetch block, slave = its surroundings (CSR decode, memory, adder).
interface add_num_operand_fetch_if #(
    parameter int OP_W = add_num_pkg::DEFAULT_OP_W
);

    logic                              cmd_valid;
    logic                              cmd_ready;
    logic [add_num_pkg::CL_ADDR_W-1:0] cmd_addr;

    logic                              c0_req_valid;
    logic [add_num_pkg::CL_ADDR_W-1:0] c0_req_addr;
    logic [add_num_pkg::MDATA_W-1:0]   c0_req_mdata;
    logic                              c0_tx_alm_full;

    logic                              c0_rsp_valid;
    logic [add_num_pkg::MDATA_W-1:0]   c0_rsp_mdata;
    logic [add_num_pkg::CL_DATA_W-1:0] c0_rsp_data;

    logic                              op_valid;
    logic                              op_ready;
    logic [OP_W-1:0]                   op_a;
    logic [OP_W-1:0]                   op_b;

    modport master (
        input  cmd_valid, cmd_addr,
        output cmd_ready,
        output c0_req_valid, c0_req_addr, c0_req_mdata,
        input  c0_tx_alm_full,
        input  c0_rsp_valid, c0_rsp_mdata, c0_rsp_data,
        output op_valid, op_a, op_b,
        input  op_ready
    );

    modport slave (
        output cmd_valid, cmd_addr,
        input  cmd_ready,
        input  c0_req_valid, c0_req_addr, c0_req_mdata,
        output c0_tx_alm_full,
        output c0_rsp_valid, c0_rsp_mdata, c0_rsp_data,
        input  op_valid, op_a, op_b,
        output op_ready
    );

endinterface

// File: rtl/add_num_fetch_timer.sv
// Clearable up-counter guarding the wait for a memory read response.
// tc_o flags the last permitted cycle (count == TIMEOUT_CYCLES-1).
module add_num_fetch_timer #(
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Clear has priority so a new request always starts from zero.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc_o = (count_q == TERMINAL);

endmodule

// File: rtl/add_num_operand_fetch.sv
// Operand-fetch stage: issues one c0 read per command, matches the tagged
// response, and hands the two low operands to the adder stage.
module add_num_operand_fetch
    import add_num_pkg::*;
#(
    parameter int          OP_W           = DEFAULT_OP_W,
    parameter int          TIMEOUT_CYCLES = 4096,
    parameter logic [11:0] MDATA_TAG      = DEFAULT_MDATA_TAG
) (
    input  logic                          clk,
    input  logic                          reset_n,
    add_num_operand_fetch_if.master       bus,
    input  logic                          err_clr,
    output logic                          busy,
    output logic                          err_timeout
);

    t_fetch_state          state_q, state_d;
    logic [SEQ_W-1:0]      seq_q, seq_d;
    logic                  c0_req_valid_q, c0_req_valid_d;
    logic [CL_ADDR_W-1:0]  c0_req_addr_q, c0_req_addr_d;
    logic [MDATA_W-1:0]    c0_req_mdata_q, c0_req_mdata_d;
    logic                  op_valid_q, op_valid_d;
    logic [OP_W-1:0]       op_a_q, op_a_d;
    logic [OP_W-1:0]       op_b_q, op_b_d;
    logic                  err_timeout_q, err_timeout_d;

    logic                  timer_clr;
    logic                  timer_en;
    logic                  timer_tc;
    logic                  rsp_match;
    logic                  unused_rsp_bits;

    add_num_fetch_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clr_i   (timer_clr),
        .en_i    (timer_en),
        .tc_o    (timer_tc)
    );

    // The held request tag identifies the one outstanding read; anything else is stale.
    assign rsp_match = bus.c0_rsp_valid && (bus.c0_rsp_mdata == c0_req_mdata_q);

    assign unused_rsp_bits = ^bus.c0_rsp_data[CL_DATA_W-1:2*OP_W];

    always_comb begin
        state_d        = state_q;
        seq_d          = seq_q;
        c0_req_valid_d = 1'b0;
        c0_req_addr_d  = c0_req_addr_q;
        c0_req_mdata_d = c0_req_mdata_q;
        op_valid_d     = op_valid_q;
        op_a_d         = op_a_q;
        op_b_d         = op_b_q;
        err_timeout_d  = err_timeout_q & ~err_clr;
        timer_clr      = 1'b0;
        timer_en       = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    c0_req_addr_d = bus.cmd_addr;
                    state_d       = REQ;
                end
            end

            REQ: begin
                if (!bus.c0_tx_alm_full) begin
                    c0_req_valid_d = 1'b1;
                    c0_req_mdata_d = make_mdata(MDATA_TAG, seq_q);
                    seq_d          = seq_q + SEQ_W'(1);
                    timer_clr      = 1'b1;
                    state_d        = WAIT_RSP;
                end
            end

            WAIT_RSP: begin
                timer_en = 1'b1;
                // A matching response in the expiry cycle still wins over the timeout.
                if (rsp_match) begin
                    op_a_d     = bus.c0_rsp_data[OP_W-1:0];
                    op_b_d     = bus.c0_rsp_data[2*OP_W-1:OP_W];
                    op_valid_d = 1'b1;
                    state_d    = OUT;
                end else if (timer_tc) begin
                    err_timeout_d = 1'b1;
                    state_d       = IDLE;
                end
            end

            OUT: begin
                if (bus.op_ready) begin
                    op_valid_d = 1'b0;
                    state_d    = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            seq_q          <= '0;
            c0_req_valid_q <= 1'b0;
            c0_req_addr_q  <= '0;
            c0_req_mdata_q <= '0;
            op_valid_q     <= 1'b0;
            op_a_q         <= '0;
            op_b_q         <= '0;
            err_timeout_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            seq_q          <= seq_d;
            c0_req_valid_q <= c0_req_valid_d;
            c0_req_addr_q  <= c0_req_addr_d;
            c0_req_mdata_q <= c0_req_mdata_d;
            op_valid_q     <= op_valid_d;
            op_a_q         <= op_a_d;
            op_b_q         <= op_b_d;
            err_timeout_q  <= err_timeout_d;
        end
    end

    assign bus.cmd_ready    = (state_q == IDLE);
    assign busy             = (state_q != IDLE);
    assign bus.c0_req_valid = c0_req_valid_q;
    assign bus.c0_req_addr  = c0_req_addr_q;
    assign bus.c0_req_mdata = c0_req_mdata_q;
    assign bus.op_valid     = op_valid_q;
    assign bus.op_a         = op_a_q;
    assign bus.op_b         = op_b_q;
    assign err_timeout      = err_timeout_q;

endmodule

// File: tb/tb_add_num_operand_fetch.sv
// Directed plus randomized bench for add_num_operand_fetch with TIMEOUT_CYCLES=16.
// Expected tags and operands come from a small transaction-level model.
module tb_add_num_operand_fetch;

    localparam int TMO = 16;

    logic clk;
    logic resetN;
    logic errClr;
    logic busy;
    logic errTimeout;

    int checks = 0;
    int errors = 0;
    int issued = 0;
    logic [15:0] lastTag;

    add_num_operand_fetch_if #(.OP_W(8)) bus ();

    add_num_operand_fetch #(
        .OP_W           (8),
        .TIMEOUT_CYCLES (TMO),
        .MDATA_TAG      (12'hADD)
    ) dut (
        .clk         (clk),
        .reset_n     (resetN),
        .bus         (bus),
        .err_clr     (errClr),
        .busy        (busy),
        .err_timeout (errTimeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: time limit reached, observed running expected finished");
        $fatal(1, "[TB] watchdog expired");
    end

    // Model: the n-th request since reset carries tag 0xADD0 plus n modulo 16.
    function automatic logic [15:0] expectedTag();
        return 16'hADD0 + 16'(issued % 16);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [41:0] addr, input logic almFull);
        bus.cmd_valid      = 1'b1;
        bus.cmd_addr       = addr;
        bus.c0_tx_alm_full = almFull;
        tick();
        bus.cmd_valid      = 1'b0;
    endtask

    task automatic driveRsp(input logic [15:0] tag, input logic [511:0] d);
        bus.c0_rsp_valid = 1'b1;
        bus.c0_rsp_mdata = tag;
        bus.c0_rsp_data  = d;
    endtask

    task automatic runFetch(input logic [41:0] addr, input logic [511:0] data, input int lat,
                            input int almCyc, input int stall, input bit injectBad,
                            input logic [15:0] badTag);
        logic [15:0] expTag;
        logic [7:0]  expA;
        logic [7:0]  expB;
        expTag = expectedTag();
        expA   = 8'(data % 256);
        expB   = 8'((data / 256) % 256);

        checkOutput("cmd_ready_idle", 64'(bus.cmd_ready), 64'd1);
        applyStimulus(addr, almCyc > 0);
        checkOutput("busy_after_accept", 64'(busy), 64'd1);
        for (int i = 0; i < almCyc; i++) begin
            checkOutput("no_req_while_alm_full", 64'(bus.c0_req_valid), 64'd0);
            tick();
        end
        bus.c0_tx_alm_full = 1'b0;
        checkOutput("no_req_before_issue", 64'(bus.c0_req_valid), 64'd0);
        tick();
        checkOutput("req_valid", 64'(bus.c0_req_valid), 64'd1);
        checkOutput("req_addr", 64'(bus.c0_req_addr), 64'(addr));
        checkOutput("req_mdata", 64'(bus.c0_req_mdata), 64'(expTag));
        issued++;

        bus.cmd_valid = 1'b1;
        bus.cmd_addr  = ~addr;
        for (int i = 0; i < lat; i++) begin
            if (injectBad && i == lat - 1) driveRsp(badTag, ~data);
            tick();
            bus.c0_rsp_valid = 1'b0;
            checkOutput("req_single_pulse", 64'(bus.c0_req_valid), 64'd0);
            checkOutput("no_op_before_match", 64'(bus.op_valid), 64'd0);
            checkOutput("cmd_blocked_busy", 64'(bus.cmd_ready), 64'd0);
        end
        bus.cmd_valid = 1'b0;

        driveRsp(expTag, data);
        tick();
        bus.c0_rsp_valid = 1'b0;
        checkOutput("op_valid", 64'(bus.op_valid), 64'd1);
        checkOutput("op_a", 64'(bus.op_a), 64'(expA));
        checkOutput("op_b", 64'(bus.op_b), 64'(expB));

        for (int i = 0; i < stall; i++) begin
            tick();
            checkOutput("stall_op_valid", 64'(bus.op_valid), 64'd1);
            checkOutput("stall_op_a", 64'(bus.op_a), 64'(expA));
            checkOutput("stall_op_b", 64'(bus.op_b), 64'(expB));
            checkOutput("stall_cmd_ready", 64'(bus.cmd_ready), 64'd0);
        end
        bus.op_ready = 1'b1;
        tick();
        bus.op_ready = 1'b0;
        checkOutput("op_valid_dropped", 64'(bus.op_valid), 64'd0);
        checkOutput("cmd_ready_after_xfer", 64'(bus.cmd_ready), 64'd1);
        checkOutput("idle_after_xfer", 64'(busy), 64'd0);
    endtask

    task automatic runTimeout(input logic [41:0] addr, input logic [511:0] data,
                              input bit rspAtExpiry, input bit clrAtExpiry);
        logic [15:0] expTag;
        expTag  = expectedTag();
        lastTag = expTag;
        applyStimulus(addr, 1'b0);
        tick();
        checkOutput("tmo_req_valid", 64'(bus.c0_req_valid), 64'd1);
        checkOutput("tmo_req_mdata", 64'(bus.c0_req_mdata), 64'(expTag));
        issued++;
        for (int i = 0; i < TMO - 1; i++) tick();
        checkOutput("tmo_still_waiting", 64'(busy), 64'd1);
        checkOutput("tmo_no_err_yet", 64'(errTimeout), 64'd0);
        if (rspAtExpiry) driveRsp(expTag, data);
        errClr = clrAtExpiry;
        tick();
        bus.c0_rsp_valid = 1'b0;
        errClr = 1'b0;
        if (rspAtExpiry) begin
            checkOutput("expiry_rsp_op_valid", 64'(bus.op_valid), 64'd1);
            checkOutput("expiry_rsp_no_err", 64'(errTimeout), 64'd0);
            checkOutput("expiry_rsp_op_a", 64'(bus.op_a), 64'(data % 256));
            bus.op_ready = 1'b1;
            tick();
            bus.op_ready = 1'b0;
            checkOutput("expiry_rsp_idle", 64'(busy), 64'd0);
        end else begin
            checkOutput("tmo_err_set", 64'(errTimeout), 64'd1);
            checkOutput("tmo_no_op_valid", 64'(bus.op_valid), 64'd0);
            checkOutput("tmo_back_idle", 64'(busy), 64'd0);
            checkOutput("tmo_cmd_ready", 64'(bus.cmd_ready), 64'd1);
        end
    endtask

    initial begin
        logic [41:0]  a;
        logic [511:0] d;
        logic [15:0]  staleTag;

        resetN             = 1'b0;
        errClr             = 1'b0;
        bus.cmd_valid      = 1'b0;
        bus.cmd_addr       = '0;
        bus.c0_tx_alm_full = 1'b0;
        bus.c0_rsp_valid   = 1'b0;
        bus.c0_rsp_mdata   = '0;
        bus.c0_rsp_data    = '0;
        bus.op_ready       = 1'b0;

        #12;
        checkOutput("rst_req_valid", 64'(bus.c0_req_valid), 64'd0);
        checkOutput("rst_req_addr", 64'(bus.c0_req_addr), 64'd0);
        checkOutput("rst_req_mdata", 64'(bus.c0_req_mdata), 64'd0);
        checkOutput("rst_op_valid", 64'(bus.op_valid), 64'd0);
        checkOutput("rst_op_a", 64'(bus.op_a), 64'd0);
        checkOutput("rst_op_b", 64'(bus.op_b), 64'd0);
        checkOutput("rst_err", 64'(errTimeout), 64'd0);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
        #4;
        resetN = 1'b1;
        tick();

        $display("[TB] basic fetch");
        for (int k = 0; k < 16; k++) d[k*32 +: 32] = $urandom;
        d[15:0] = 16'h0305;
        runFetch(42'h1000, d, 10, 0, 0, 1'b0, 16'h0000);

        $display("[TB] tag filtering");
        for (int k = 0; k < 16; k++) d[k*32 +: 32] = $urandom;
        runFetch(42'h2040, d, 3, 0, 0, 1'b1, 16'hADD5);

        $display("[TB] back-pressure");
        for (int k = 0; k < 16; k++) d[k*32 +: 32] = $urandom;
        runFetch(42'h3_0000_0080, d, 2, 20, 0, 1'b0, 16'h0000);

        $display("[TB] downstream stall");
        for (int k = 0; k < 16; k++) d[k*32 +: 32] = $urandom;
        runFetch(42'h77, d, 4, 0, 5, 1'b0, 16'h0000);

        $display("[TB] timeout with err_clr at expiry");
        runTimeout(42'h1234, d, 1'b0, 1'b1);
        driveRsp(lastTag, d);
        tick();
        bus.c0_rsp_valid = 1'b0;
        checkOutput("stale_rsp_no_op_valid", 64'(bus.op_valid), 64'd0);
        checkOutput("stale_rsp_idle", 64'(busy), 64'd0);
        errClr = 1'b1;
        tick();
        errClr = 1'b0;
        checkOutput("err_clr_clears", 64'(errTimeout), 64'd0);

        $display("[TB] response in expiry cycle");
        for (int k = 0; k < 16; k++) d[k*32 +: 32] = $urandom;
        runTimeout(42'h5678, d, 1'b1, 1'b0);

        $display("[TB] randomized fetches");
        for (int n = 0; n < 20; n++) begin
            a = {10'($urandom), $urandom};
            for (int k = 0; k < 16; k++) d[k*32 +: 32] = $urandom;
            runFetch(a, d, int'($urandom_range(1, 8)), int'($urandom_range(0, 3)),
                     int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                     expectedTag() ^ 16'($urandom_range(1, 65535)));
        end

        $display("[TB] reset mid-WAIT_RSP");
        staleTag = expectedTag();
        applyStimulus(42'h9999, 1'b0);
        tick();
        checkOutput("pre_rst_req_valid", 64'(bus.c0_req_valid), 64'd1);
        tick();
        tick();
        resetN = 1'b0;
        #2;
        checkOutput("async_rst_busy", 64'(busy), 64'd0);
        checkOutput("async_rst_req_valid", 64'(bus.c0_req_valid), 64'd0);
        checkOutput("async_rst_req_addr", 64'(bus.c0_req_addr), 64'd0);
        checkOutput("async_rst_req_mdata", 64'(bus.c0_req_mdata), 64'd0);
        checkOutput("async_rst_op_valid", 64'(bus.op_valid), 64'd0);
        checkOutput("async_rst_op_a", 64'(bus.op_a), 64'd0);
        checkOutput("async_rst_op_b", 64'(bus.op_b), 64'd0);
        #3;
        resetN = 1'b1;
        issued = 0;
        tick();
        driveRsp(staleTag, d);
        tick();
        bus.c0_rsp_valid = 1'b0;
        checkOutput("late_rsp_dropped", 64'(bus.op_valid), 64'd0);
        for (int k = 0; k < 16; k++) d[k*32 +: 32] = $urandom;
        runFetch(42'h4242, d, 5, 0, 1, 1'b1, staleTag);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
